// File: rtl/mmu_pkg.sv
// Shared definitions for the page-table walker: FSM encoding, PTE field positions,
// presentation hold lengths and bus response codes.
package mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_RECV    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DRAIN   = 3'd4
    } walk_state_e;

    localparam int PTE_W         = 64;
    localparam int PTE_CRCPT_BIT = 63;
    localparam int HOLD_CRCPT    = 3;
    localparam int HOLD_RCPT     = 2;
    localparam int HOLD_W        = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Remaining cycles after the first one for which a data PTE stays on the update port.
    function automatic logic [HOLD_W-1:0] pte_hold_remaining(input logic [PTE_W-1:0] pte);
        return pte[PTE_CRCPT_BIT] ? HOLD_W'(HOLD_CRCPT - 1) : HOLD_W'(HOLD_RCPT - 1);
    endfunction

endpackage

// File: rtl/mmu_pte_buffer.sv
// Store-and-forward buffer for one PTE group: anchor in slot 0, data PTEs after it.
// Unwritten slots read back as zero.
module mmu_pte_buffer
    import mmu_pkg::*;
#(
    parameter int SLOTS = 3,
    parameter int IDX_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [PTE_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [PTE_W-1:0] o_rd_data
);

    logic [PTE_W-1:0] mem_q [SLOTS];
    logic [PTE_W-1:0] mem_d [SLOTS];
    logic [SLOTS-1:0] valid_q;
    logic [SLOTS-1:0] valid_d;

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (i_clr) begin
            valid_d = '0;
        end
        if (i_wr_en && (int'(i_wr_idx) < SLOTS)) begin
            mem_d[i_wr_idx]   = i_wr_data;
            valid_d[i_wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only visible through its valid bit.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        o_rd_data = '0;
        if ((int'(i_rd_idx) < SLOTS) && valid_q[i_rd_idx]) begin
            o_rd_data = mem_q[i_rd_idx];
        end
    end

endmodule

// File: rtl/mmu_pte_walker.sv
// Page-table walker: on a TLB miss fetches one PTE group (anchor + data PTEs), buffers it,
// then replays it on the TLB update port with per-PTE hold lengths and a round-robin victim.
module mmu_pte_walker
    import mmu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 35,
    parameter int VPN_WIDTH   = 23,
    parameter int PTE_LOG2    = 1,
    parameter int TLB_ENTRIES = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_miss,
    input  logic [ADDR_WIDTH-1:0]          i_missVAddr,
    input  logic [ADDR_WIDTH-1:0]          i_ptBase,
    output logic                           o_busy,
    output logic                           o_arvalid,
    input  logic                           i_arready,
    output logic [ADDR_WIDTH-1:0]          o_araddr,
    output logic [7:0]                     o_arlen,
    input  logic                           i_rvalid,
    output logic                           o_rready,
    input  logic [63:0]                    i_rdata,
    input  logic [1:0]                     i_rresp,
    input  logic                           i_rlast,
    output logic                           o_ptwUpdate,
    output logic [63:0]                    o_ptwPTE,
    output logic [$clog2(TLB_ENTRIES)-1:0] o_indexVictim,
    output logic                           o_walkError
);

    localparam int PTE_GROUP = 1 << PTE_LOG2;
    localparam int SLOTS     = PTE_GROUP + 1;
    localparam int IDX_W     = $clog2(SLOTS);
    localparam int BEAT_W    = $clog2(SLOTS + 1);
    localparam int VIC_W     = $clog2(TLB_ENTRIES);

    walk_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        slot_q, slot_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [PTE_W-1:0]        pte_q, pte_d;
    logic [VIC_W-1:0]        victim_q, victim_d;

    logic [VPN_WIDTH-1:0]    vpn;
    logic [ADDR_WIDTH-1:0]   grp_idx;
    logic [ADDR_WIDTH-1:0]   walk_addr;
    logic                    unused_va_offset;
    logic                    beat_fire;
    logic                    exp_last;
    logic                    beat_err;
    logic                    err_now;
    logic                    last_slot;
    logic                    hold_done;
    logic                    buf_clr;
    logic                    buf_wr_en;
    logic [IDX_W-1:0]        buf_rd_idx;
    logic [PTE_W-1:0]        buf_rd_data;

    // Group address = base + group_index * (PTE_GROUP+1) * 8, as two shifted adds.
    assign vpn              = i_missVAddr[ADDR_WIDTH-1 -: VPN_WIDTH];
    assign grp_idx          = ADDR_WIDTH'(vpn >> PTE_LOG2);
    assign walk_addr        = i_ptBase + (grp_idx << (PTE_LOG2 + 3)) + (grp_idx << 3);
    assign unused_va_offset = ^i_missVAddr[ADDR_WIDTH-VPN_WIDTH-1:0];

    // A short or long burst is flagged the same way as a bad response.
    assign beat_fire = (state_q == ST_RECV) && i_rvalid;
    assign exp_last  = (beat_q == BEAT_W'(PTE_GROUP));
    assign beat_err  = (i_rresp != RESP_OKAY) || (i_rlast != exp_last);
    assign err_now   = err_q || beat_err;
    assign last_slot = (slot_q == IDX_W'(PTE_GROUP));
    assign hold_done = (hold_q == '0);

    assign buf_clr    = (state_q == ST_IDLE) && i_miss;
    assign buf_wr_en  = beat_fire && (beat_q < BEAT_W'(SLOTS));
    assign buf_rd_idx = (state_q == ST_PRESENT) ? slot_q + 1'b1 : '0;

    mmu_pte_buffer #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W)
    ) u_buffer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (buf_clr),
        .i_wr_en   (buf_wr_en),
        .i_wr_idx  (IDX_W'(beat_q)),
        .i_wr_data (i_rdata),
        .i_rd_idx  (buf_rd_idx),
        .o_rd_data (buf_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (i_miss) state_d = ST_REQ;
            ST_REQ:     if (i_arready) state_d = ST_RECV;
            ST_RECV:    if (beat_fire && i_rlast) state_d = err_now ? ST_DRAIN : ST_PRESENT;
            ST_PRESENT: if (hold_done && last_slot) state_d = ST_IDLE;
            ST_DRAIN:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (state_q != ST_IDLE);
        o_arvalid     = (state_q == ST_REQ);
        o_rready      = (state_q == ST_RECV);
        o_ptwUpdate   = (state_q == ST_PRESENT);
        o_walkError   = (state_q == ST_DRAIN);
        o_araddr      = araddr_q;
        o_arlen       = arlen_q;
        o_ptwPTE      = pte_q;
        o_indexVictim = victim_q;
    end

    always_comb begin
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        beat_d   = beat_q;
        err_d    = err_q;
        slot_d   = slot_q;
        hold_d   = hold_q;
        pte_d    = pte_q;
        victim_d = victim_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_miss) begin
                    araddr_d = walk_addr;
                    arlen_d  = 8'(PTE_GROUP);
                    beat_d   = '0;
                    err_d    = 1'b0;
                end
            end
            ST_RECV: begin
                if (beat_fire) begin
                    if (beat_q != BEAT_W'(SLOTS)) beat_d = beat_q + 1'b1;
                    err_d = err_now;
                    // Anchor is already buffered, so it can go out on the first PRESENT cycle.
                    if (i_rlast && !err_now) begin
                        slot_d = '0;
                        hold_d = '0;
                        pte_d  = buf_rd_data;
                    end
                end
            end
            ST_PRESENT: begin
                victim_d = (victim_q == VIC_W'(TLB_ENTRIES - 1)) ? '0 : victim_q + 1'b1;
                if (hold_done) begin
                    if (!last_slot) begin
                        slot_d = slot_q + 1'b1;
                        pte_d  = buf_rd_data;
                        hold_d = pte_hold_remaining(buf_rd_data);
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            araddr_q <= '0;
            arlen_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            slot_q   <= '0;
            hold_q   <= '0;
            pte_q    <= '0;
            victim_q <= '0;
        end else begin
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            slot_q   <= slot_d;
            hold_q   <= hold_d;
            pte_q    <= pte_d;
            victim_q <= victim_d;
        end
    end

endmodule
